// File: rtl/tone_seq.sv
// tone_seq: multi-tune piezo sequencer with a runtime-writable note table and fixed-priority arbitration.
// Optional build macro TONE_SEQ_LOOP_EN adds the per-tune loop input for continuous replay.
module tone_seq #(
  parameter int          NUM_TUNES  = 3,
  parameter int          MAX_NOTES  = 8,
  parameter int          HP_W       = 16,
  parameter int          DUR_W      = 5,
  parameter int unsigned REPEAT_CYC = 150000000,
  parameter int          FAST_SIM   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_TUNES-1:0]         req,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_TUNES)-1:0] cfg_tune,
  input  logic [$clog2(MAX_NOTES)-1:0] cfg_idx,
  input  logic [HP_W-1:0]              cfg_hp,
  input  logic [DUR_W-1:0]             cfg_dur,
  input  logic                         cfg_last,
`ifdef TONE_SEQ_LOOP_EN
  input  logic [NUM_TUNES-1:0]         loop,
`endif
  output logic                         piezo,
  output logic                         piezo_n,
  output logic                         busy,
  output logic [$clog2(NUM_TUNES)-1:0] cur_tune
);

  localparam int TW   = $clog2(NUM_TUNES);
  localparam int IW   = $clog2(MAX_NOTES);
  localparam int DCW  = (1 << DUR_W) + 1;
  localparam int STEP = (FAST_SIM != 0) ? 64 : 1;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_LOAD} state_t;

  logic [HP_W-1:0]  r_tab_hp   [NUM_TUNES][MAX_NOTES];
  logic [DUR_W-1:0] r_tab_dur  [NUM_TUNES][MAX_NOTES];
  logic             r_tab_last [NUM_TUNES][MAX_NOTES];

  state_t           r_state, w_nx_state;
  logic [NUM_TUNES-1:0] r_req;
  logic [TW-1:0]    r_tune, w_nx_tune;
  logic [IW-1:0]    r_idx, w_nx_idx;
  logic [HP_W-1:0]  r_hp, w_nx_hp;
  logic [DUR_W-1:0] r_dur, w_nx_dur;
  logic             r_last, w_nx_last;
  logic [HP_W-1:0]  r_tcnt, w_nx_tcnt;
  logic [DCW-1:0]   r_dcnt, w_nx_dcnt;
  logic [31:0]      r_rep, w_nx_rep;
  logic             r_piezo, w_nx_piezo;
  logic             r_piezo_n, w_nx_piezo_n;

  logic             w_any;
  logic [TW-1:0]    w_win;
  logic             w_load, w_reload, w_end;
  logic [TW-1:0]    w_ld_tune;
  logic [IW-1:0]    w_ld_idx;
  logic [HP_W-1:0]  w_rd_hp;
  logic [DUR_W-1:0] w_rd_dur;
  logic             w_rd_last;
  logic [DCW-1:0]   w_dcnt_inc, w_dur_lim;

  // NOTE: the note table is built from flops and cleared by reset, so it needs
  // explicit reset loops; a RAM macro would not give the cleared-on-reset contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NUM_TUNES; t++) begin
        for (int n = 0; n < MAX_NOTES; n++) begin
          r_tab_hp[t][n]   <= '0;
          r_tab_dur[t][n]  <= '0;
          r_tab_last[t][n] <= 1'b0;
        end
      end
    end else if (cfg_we && (int'(cfg_tune) < NUM_TUNES) && (int'(cfg_idx) < MAX_NOTES)) begin
      r_tab_hp[cfg_tune][cfg_idx]   <= cfg_hp;
      r_tab_dur[cfg_tune][cfg_idx]  <= cfg_dur;
      r_tab_last[cfg_tune][cfg_idx] <= cfg_last;
    end
  end

  // Combinational read: a write on the same edge as a load still yields the old entry.
  assign w_rd_hp    = r_tab_hp[w_ld_tune][w_ld_idx];
  assign w_rd_dur   = r_tab_dur[w_ld_tune][w_ld_idx];
  assign w_rd_last  = r_tab_last[w_ld_tune][w_ld_idx];
  assign w_dcnt_inc = r_dcnt + DCW'(STEP);
  assign w_dur_lim  = DCW'(1) << r_dur;

  always_comb begin
    w_any = |r_req;
    w_win = '0;
    for (int i = NUM_TUNES - 1; i >= 0; i--) begin
      if (r_req[i]) w_win = TW'(i);
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case/if tree leaves a value unassigned and infers a latch.
  always_comb begin
    w_load    = 1'b0;
    w_reload  = 1'b0;
    w_end     = 1'b0;
    w_ld_tune = r_tune;
    w_ld_idx  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any && ((w_win == '0) || (r_rep == '0))) begin
          w_load    = 1'b1;
          w_reload  = 1'b1;
          w_ld_tune = w_win;
        end
      end
      S_LOAD: begin
        if (w_any && (w_win < r_tune)) begin
          w_load    = 1'b1;
          w_reload  = 1'b1;
          w_ld_tune = w_win;
        end else if (r_last || (r_idx == IW'(MAX_NOTES - 1))) begin
`ifdef TONE_SEQ_LOOP_EN
          if (loop[r_tune] && r_req[r_tune]) w_load = 1'b1;
          else                               w_end  = 1'b1;
`else
          w_end = 1'b1;
`endif
        end else begin
          w_load   = 1'b1;
          w_ld_idx = r_idx + IW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_nx_state   = r_state;
    w_nx_tune    = r_tune;
    w_nx_idx     = r_idx;
    w_nx_hp      = r_hp;
    w_nx_dur     = r_dur;
    w_nx_last    = r_last;
    w_nx_tcnt    = r_tcnt;
    w_nx_dcnt    = r_dcnt;
    w_nx_piezo   = r_piezo;
    w_nx_piezo_n = r_piezo_n;
    w_nx_rep     = (r_rep > 32'(STEP)) ? (r_rep - 32'(STEP)) : '0;
    if (w_reload) w_nx_rep = 32'(REPEAT_CYC);

    case (r_state)
      S_IDLE: begin
        w_nx_piezo   = 1'b0;
        w_nx_piezo_n = 1'b0;
      end
      S_PLAY: begin
        w_nx_dcnt = w_dcnt_inc;
        if (r_hp == '0) begin
          w_nx_tcnt = '0;
        end else if (r_tcnt == r_hp) begin
          w_nx_tcnt    = '0;
          w_nx_piezo   = ~r_piezo;
          w_nx_piezo_n = r_piezo;
        end else begin
          w_nx_tcnt = r_tcnt + HP_W'(1);
        end
        if (w_dcnt_inc >= w_dur_lim) w_nx_state = S_LOAD;
      end
      S_LOAD: begin
        if (w_end) begin
          w_nx_state   = S_IDLE;
          w_nx_tune    = '0;
          w_nx_idx     = '0;
          w_nx_piezo   = 1'b0;
          w_nx_piezo_n = 1'b0;
        end
      end
      default: w_nx_state = S_IDLE;
    endcase

    // Every note start begins low on piezo; piezo_n idles high unless the note is a rest.
    if (w_load) begin
      w_nx_state   = S_PLAY;
      w_nx_tune    = w_ld_tune;
      w_nx_idx     = w_ld_idx;
      w_nx_hp      = w_rd_hp;
      w_nx_dur     = w_rd_dur;
      w_nx_last    = w_rd_last;
      w_nx_tcnt    = '0;
      w_nx_dcnt    = '0;
      w_nx_piezo   = 1'b0;
      w_nx_piezo_n = (w_rd_hp != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_req     <= '0;
      r_tune    <= '0;
      r_idx     <= '0;
      r_hp      <= '0;
      r_dur     <= '0;
      r_last    <= 1'b0;
      r_tcnt    <= '0;
      r_dcnt    <= '0;
      r_rep     <= '0;
      r_piezo   <= 1'b0;
      r_piezo_n <= 1'b0;
    end else begin
      r_state   <= w_nx_state;
      r_req     <= req;
      r_tune    <= w_nx_tune;
      r_idx     <= w_nx_idx;
      r_hp      <= w_nx_hp;
      r_dur     <= w_nx_dur;
      r_last    <= w_nx_last;
      r_tcnt    <= w_nx_tcnt;
      r_dcnt    <= w_nx_dcnt;
      r_rep     <= w_nx_rep;
      r_piezo   <= w_nx_piezo;
      r_piezo_n <= w_nx_piezo_n;
    end
  end

  assign piezo    = r_piezo;
  assign piezo_n  = r_piezo_n;
  assign busy     = (r_state != S_IDLE);
  assign cur_tune = r_tune;

endmodule

// File: tb/tb_tone_seq.sv
// Self-checking bench for tone_seq: table-driven tune vectors plus hand-written corner sequences,
// with a per-cycle expected-output queue compared one cycle at a time.
module tb_tone_seq;

  localparam int RC = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic        cfg_we;
  logic [1:0]  cfg_tune;
  logic [2:0]  cfg_idx;
  logic [15:0] cfg_hp;
  logic [4:0]  cfg_dur;
  logic        cfg_last;
`ifdef TONE_SEQ_LOOP_EN
  logic [2:0]  loop;
`endif
  logic        piezo, piezo_n, busy;
  logic [1:0]  cur_tune;

  tone_seq #(
    .NUM_TUNES(3), .MAX_NOTES(8), .HP_W(16), .DUR_W(5),
    .REPEAT_CYC(RC), .FAST_SIM(0)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .cfg_we(cfg_we), .cfg_tune(cfg_tune), .cfg_idx(cfg_idx),
    .cfg_hp(cfg_hp), .cfg_dur(cfg_dur), .cfg_last(cfg_last),
`ifdef TONE_SEQ_LOOP_EN
    .loop(loop),
`endif
    .piezo(piezo), .piezo_n(piezo_n), .busy(busy), .cur_tune(cur_tune)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       p;
    logic       pn;
    logic [1:0] tune;
  } obs_t;

  typedef struct {
    logic [1:0]        tune;
    int                n;
    logic [7:0][15:0]  hp;
    logic [7:0][4:0]   dur;
    logic [7:0]        last;
    int                len;
    int                pre_wait;
  } vec_t;

  obs_t exp_q[$];
  obs_t mon_e;
  vec_t vecs[4];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Output monitor: one expected record per clock, sampled just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("trace{busy,piezo,piezo_n,tune}", {27'd0, busy, piezo, piezo_n, cur_tune}, {27'd0, mon_e});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic push_rec(input logic b, input logic p, input logic pn, input logic [1:0] t);
    obs_t r;
    r.busy = b; r.p = p; r.pn = pn; r.tune = t;
    exp_q.push_back(r);
  endtask

  task automatic push_idle();
    push_rec(1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  // Square wave from the note's own hp/dur, then the one LOAD cycle that holds the outputs.
  task automatic push_note(input logic [1:0] t, input int hp, input int dur);
    logic p, pn;
    p = 1'b0; pn = 1'b0;
    for (int k = 0; k < (1 << dur); k++) begin
      p  = (hp == 0) ? 1'b0 : (((k / (hp + 1)) % 2) == 1);
      pn = (hp == 0) ? 1'b0 : !p;
      push_rec(1'b1, p, pn, t);
    end
    push_rec(1'b1, p, pn, t);
  endtask

  task automatic push_tune(input vec_t v);
    for (int i = 0; i < 8; i++) begin
      push_note(v.tune, int'(v.hp[i]), int'(v.dur[i]));
      if (v.last[i]) break;
    end
  endtask

  task automatic cfg_write(input logic [1:0] t, input int i, input logic [15:0] hp,
                           input logic [4:0] d, input logic l);
    @(negedge clk);
    cfg_we = 1'b1; cfg_tune = t; cfg_idx = 3'(i); cfg_hp = hp; cfg_dur = d; cfg_last = l;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic program_vec(input vec_t v);
    for (int i = 0; i < v.n; i++) cfg_write(v.tune, i, v.hp[i], v.dur[i], v.last[i]);
  endtask

  task automatic wait_q(input int budget);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("queue_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("return_idle", busy, 1'b0);
  endtask

  // Held request: returns first rise, fall, and second rise (negedge counts from the drive).
  task automatic measure_hold(input int limit, output int t0, output int tf, output int tr);
    logic prev;
    prev = 1'b0; t0 = -1; tf = -1; tr = -1;
    for (int t = 1; t <= limit && tr < 0; t++) begin
      @(negedge clk);
      if (busy && !prev && t0 < 0)       t0 = t;
      else if (!busy && prev && tf < 0)  tf = t;
      else if (busy && !prev && tf >= 0) tr = t;
      prev = busy;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int len, w;
    program_vec(v);
    repeat (v.pre_wait) @(negedge clk);
    @(negedge clk);
    req[v.tune] = 1'b1;
    push_idle();
    push_tune(v);
    push_idle();
    @(negedge clk);
    req = '0;
    len = 0; w = 0;
    while (!busy && w < 10) begin @(negedge clk); w++; end
    while (busy && len < 5000) begin len++; @(negedge clk); end
    check("vec_busy_len", len, v.len);
    wait_q(20);
  endtask

  int t0, tf, tr;

  initial begin
    rst = 1'b1; req = '0; cfg_we = 1'b0; cfg_tune = '0; cfg_idx = '0;
    cfg_hp = '0; cfg_dur = '0; cfg_last = 1'b0;
`ifdef TONE_SEQ_LOOP_EN
    loop = '0;
`endif
    for (int i = 0; i < 4; i++) begin
      vecs[i].hp = '0; vecs[i].dur = '0; vecs[i].last = '0; vecs[i].pre_wait = 0;
    end
    // Two-note tune 1 from the datasheet example.
    vecs[0].tune = 2'd1; vecs[0].n = 2; vecs[0].len = 130;
    vecs[0].hp[0] = 16'd9; vecs[0].dur[0] = 5'd6;
    vecs[0].hp[1] = 16'd4; vecs[0].dur[1] = 5'd6; vecs[0].last[1] = 1'b1;
    // Single rest note.
    vecs[1].tune = 2'd0; vecs[1].n = 1; vecs[1].len = 17;
    vecs[1].hp[0] = 16'd0; vecs[1].dur[0] = 5'd4; vecs[1].last[0] = 1'b1;
    // Three notes ending on a rest.
    vecs[2].tune = 2'd0; vecs[2].n = 3; vecs[2].len = 31;
    vecs[2].hp[0] = 16'd2; vecs[2].dur[0] = 5'd4;
    vecs[2].hp[1] = 16'd5; vecs[2].dur[1] = 5'd3;
    vecs[2].hp[2] = 16'd0; vecs[2].dur[2] = 5'd2; vecs[2].last[2] = 1'b1;
    // Full eight slots with no last flag: the tune ends at the final slot.
    vecs[3].tune = 2'd2; vecs[3].n = 8; vecs[3].len = 40; vecs[3].pre_wait = 1100;
    for (int i = 0; i < 8; i++) begin
      vecs[3].hp[i] = (i == 3) ? 16'd0 : 16'd2; vecs[3].dur[i] = 5'd2;
    end

    #1;
    check("rst_piezo", piezo, 1'b0);
    check("rst_piezo_n", piezo_n, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cur_tune", cur_tune, 2'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Held gated request: replay only after the repeat timer drains.
    repeat (1100) @(negedge clk);
    req[1] = 1'b1;
    measure_hold(3000, t0, tf, tr);
    check("hold_first_len", tf - t0, 130);
    check("repeat_gap_in_range", ((tr - t0) >= RC) && ((tr - t0) <= RC + 1), 1'b1);
    req = '0;
    wait_idle(200);

    // Held tune 0: end and restart are separated by at least one idle cycle.
    @(negedge clk);
    req[0] = 1'b1;
    measure_hold(200, t0, tf, tr);
    check("t0_first_len", tf - t0, 31);
    check("t0_idle_gap", ((tr - tf) >= 1) && ((tr - tf) <= 2), 1'b1);
    req = '0;
    wait_idle(100);

    // Preemption: tune 1 note 0 completes, then tune 0 runs ungated.
    repeat (1100) @(negedge clk);
    req[1] = 1'b1;
    push_idle();
    push_note(2'd1, 9, 6);
    push_tune(vecs[2]);
    push_idle();
    @(negedge clk);
    req = '0;
    repeat (20) @(negedge clk);
    req[0] = 1'b1;
    repeat (60) @(negedge clk);
    req = '0;
    wait_q(200);

    // Writes to the playing slot and to the slot being loaded both take effect only next replay.
    repeat (5) @(negedge clk);
    req[0] = 1'b1;
    push_idle();
    push_tune(vecs[2]);
    push_idle();
    @(negedge clk);
    req = '0;
    repeat (6) @(negedge clk);
    cfg_we = 1'b1; cfg_tune = 2'd0; cfg_idx = 3'd0; cfg_hp = 16'd6; cfg_dur = 5'd4; cfg_last = 1'b0;
    @(negedge clk);
    cfg_we = 1'b0;
    repeat (10) @(negedge clk);
    cfg_we = 1'b1; cfg_tune = 2'd0; cfg_idx = 3'd1; cfg_hp = 16'd8; cfg_dur = 5'd3; cfg_last = 1'b0;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_q(100);
    repeat (3) @(negedge clk);
    req[0] = 1'b1;
    push_idle();
    push_note(2'd0, 6, 4);
    push_note(2'd0, 8, 3);
    push_note(2'd0, 0, 2);
    push_idle();
    @(negedge clk);
    req = '0;
    wait_q(100);

    // Reset while the tone is high.
    repeat (3) @(negedge clk);
    req[0] = 1'b1;
    @(negedge clk);
    req = '0;
    repeat (9) @(negedge clk);
    check("pre_rst_piezo", piezo, 1'b1);
    check("pre_rst_piezo_n", piezo_n, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_piezo", piezo, 1'b0);
    check("mid_rst_piezo_n", piezo_n, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_cur_tune", cur_tune, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    // Cleared table and cleared repeat timer: tune 1 starts at once and plays 8 one-cycle rests.
    @(negedge clk);
    req[1] = 1'b1;
    push_idle();
    for (int i = 0; i < 8; i++) push_note(2'd1, 0, 0);
    push_idle();
    @(negedge clk);
    req = '0;
    wait_q(50);

`ifdef TONE_SEQ_LOOP_EN
    program_vec(vecs[0]);
    loop = 3'b010;
    repeat (1100) @(negedge clk);
    req[1] = 1'b1;
    push_idle();
    for (int i = 0; i < 3; i++) push_tune(vecs[0]);
    push_idle();
    repeat (272) @(negedge clk);
    req = '0;
    wait_q(400);
    loop = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
